sap_ram: RTL and testbench

Parametrised successor to the SAP-1 16x8 program/data memory. Adds a clocked write port from the W bus, a manual programming port that models the front-panel switches, and a synchronous registered read. A boot-initialisation state machine fills the array after reset, one word per cycle. The block sits on the W bus beside the program counter, MAR and controller. The controller drives `nCE` and `nWE` and must hold off while `busy` is high.

---
 rtl/sap_pkg.sv | 31 +++
 rtl/sap_ram_array.sv | 28 ++
 rtl/sap_ram.sv | 89 ++++++++
 tb/tb_sap_ram.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/sap_pkg.sv
// Shared constants for the SAP RAM: opcodes, boot image, FSM states and init_word().
// Optional macro SAP_RAM_BOOT_IMAGE_EN preloads the default program; otherwise boot clears the array.
package sap_pkg;

  localparam logic [3:0] OP_LDA = 4'h0;
  localparam logic [3:0] OP_ADD = 4'h1;
  localparam logic [3:0] OP_SUB = 4'h2;
  localparam logic [3:0] OP_OUT = 4'hE;
  localparam logic [3:0] OP_HLT = 4'hF;

`ifdef SAP_RAM_BOOT_IMAGE_EN
  localparam bit BOOT_EN = 1'b1;
`else
  localparam bit BOOT_EN = 1'b0;
`endif

  // LDA 10; ADD 11; ADD 12; OUT; HLT; then data words.
  localparam logic [7:0] BOOT_IMAGE [16] = '{
    {OP_LDA, 4'd10}, {OP_ADD, 4'd11}, {OP_ADD, 4'd12}, {OP_OUT, 4'd0},
    {OP_HLT, 4'd0},  8'h02, 8'h02, 8'h02,
    8'h02, 8'h02, 8'h05, 8'h07,
    8'h08, 8'h02, 8'h02, 8'h02
  };

  typedef enum logic {ST_INIT, ST_IDLE} state_t;

  function automatic logic [7:0] init_word(input logic [31:0] a);
    return (BOOT_EN && (a < 32'd16)) ? BOOT_IMAGE[a[3:0]] : 8'h00;
  endfunction

endpackage

// File: rtl/sap_ram_array.sv
// DATA_W x 2**ADDR_W storage with a single write port and a read-first registered read.
module sap_ram_array #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rd_q
);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Nonblocking update means a same-edge write is not yet visible here (read-first).
  always_ff @(posedge clk) begin
    if (clr)     rd_q <= '0;
    else if (re) rd_q <= mem[raddr];
  end

endmodule

// File: rtl/sap_ram.sv
// SAP-1 program/data RAM: boot fill FSM, bus/manual write mux, gated tristate read port.
// Optional macro SAP_RAM_BOOT_IMAGE_EN selects the default program as boot contents.
module sap_ram
  import sap_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              clr,
  input  logic [ADDR_W-1:0] address,
  input  logic              nCE,
  input  logic              nWE,
  input  logic [DATA_W-1:0] W_in,
  output logic [DATA_W-1:0] W,
  input  logic              prog_mode,
  input  logic              prog_we,
  input  logic [ADDR_W-1:0] prog_addr,
  input  logic [DATA_W-1:0] prog_data,
  output logic              busy
);

  localparam int DEPTH = 2**ADDR_W;
  localparam logic [ADDR_W:0] PTR_LAST = (ADDR_W+1)'(DEPTH-1);
  localparam logic [ADDR_W:0] PTR_ONE  = (ADDR_W+1)'(1);

  state_t            state, state_nxt;
  logic [ADDR_W:0]   ptr, ptr_nxt;
  logic              we, re;
  logic [ADDR_W-1:0] waddr;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] rd_q;

  always_ff @(posedge clk) begin
    if (clr) begin
      state <= ST_INIT;
      ptr   <= '0;
    end else begin
      state <= state_nxt;
      ptr   <= ptr_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    if (state == ST_INIT) begin
      ptr_nxt = ptr + PTR_ONE;
      if (ptr == PTR_LAST) state_nxt = ST_IDLE;
    end
  end

  // Write source: boot word during INIT, else manual port or bus depending on prog_mode.
  always_comb begin
    we    = 1'b0;
    waddr = address;
    wdata = W_in;
    if (!clr) begin
      if (state == ST_INIT) begin
        we    = 1'b1;
        waddr = ptr[ADDR_W-1:0];
        wdata = DATA_W'(init_word(32'(ptr)));
      end else if (prog_mode) begin
        we    = prog_we;
        waddr = prog_addr;
        wdata = prog_data;
      end else begin
        we    = !nWE;
      end
    end
  end

  assign re   = !clr && (state == ST_IDLE) && !nCE;
  assign busy = (state == ST_INIT);

  sap_ram_array #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_array (
    .clk   (clk),
    .clr   (clr),
    .we    (we),
    .waddr (waddr),
    .wdata (wdata),
    .re    (re),
    .raddr (address),
    .rd_q  (rd_q)
  );

  assign W = (!nCE && !busy) ? rd_q : {DATA_W{1'bz}};

endmodule

// File: tb/tb_sap_ram.sv
// Randomized and directed bench for sap_ram against an array-based memory model.
module tb_sap_ram;

`ifdef SAP_RAM_BOOT_IMAGE_EN
  localparam bit TB_BOOT = 1'b1;
`else
  localparam bit TB_BOOT = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       clr;
  logic [3:0] address;
  logic       nCE, nWE;
  logic [7:0] W_in;
  wire  [7:0] W;
  logic       prog_mode, prog_we;
  logic [3:0] prog_addr;
  logic [7:0] prog_data;
  logic       busy;

  logic [4:0] a5;
  logic       nCE5;
  wire  [7:0] W5;
  logic       busy5;

  logic [7:0] ZZ = 8'hzz;
  logic [7:0] ref_mem [16];
  logic [7:0] exp_rd;
  int         n_checks = 0;
  int         n_errs   = 0;

  always #5 clk = ~clk;

  sap_ram #(.DATA_W(8), .ADDR_W(4)) u_dut (
    .clk(clk), .clr(clr), .address(address), .nCE(nCE), .nWE(nWE), .W_in(W_in), .W(W),
    .prog_mode(prog_mode), .prog_we(prog_we), .prog_addr(prog_addr), .prog_data(prog_data),
    .busy(busy)
  );

  sap_ram #(.DATA_W(8), .ADDR_W(5)) u_dut5 (
    .clk(clk), .clr(clr), .address(a5), .nCE(nCE5), .nWE(1'b1), .W_in(8'h00), .W(W5),
    .prog_mode(1'b0), .prog_we(1'b0), .prog_addr(5'd0), .prog_data(8'h00),
    .busy(busy5)
  );

  // Boot contents as listed for the SAP-1 default program.
  function automatic logic [7:0] exp_init(input int a);
    logic [7:0] v;
    case (a)
      0: v = 8'h0A;  1: v = 8'h1B;  2: v = 8'h1C;  3: v = 8'hE0;  4: v = 8'hF0;
      5, 6, 7, 8, 9: v = 8'h02;
      10: v = 8'h05; 11: v = 8'h07; 12: v = 8'h08;
      13, 14, 15: v = 8'h02;
      default: v = 8'h00;
    endcase
    return TB_BOOT ? v : 8'h00;
  endfunction

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Releases clr and times both boot sequences; a write attempt may be pending on nWE.
  task automatic run_init();
    int fall4, fall5;
    fall4 = -1;
    fall5 = -1;
    clr = 1'b0;
    for (int c = 1; c <= 100; c++) begin
      step();
      if (fall4 < 0 && busy) chk("w_z_busy", 16'(W), 16'(ZZ));
      if (fall4 < 0 && !busy) begin
        fall4 = c;
        chk("rdq_reset", 16'(W), 16'h0000);
        nWE = 1'b1;
      end
      if (fall5 < 0 && !busy5) fall5 = c;
      if (fall4 >= 0 && fall5 >= 0) break;
    end
    chk("busy_cycles4", 16'(fall4), 16'd16);
    chk("busy_cycles5", 16'(fall5), 16'd32);
    for (int i = 0; i < 16; i++) ref_mem[i] = exp_init(i);
  endtask

  initial begin
    clr = 1'b1; address = 4'd0; nCE = 1'b0; nWE = 1'b1; W_in = 8'h00;
    prog_mode = 1'b0; prog_we = 1'b0; prog_addr = 4'd0; prog_data = 8'h00;
    a5 = 5'd0; nCE5 = 1'b1;

    step();
    chk("reset_busy", 16'(busy), 16'd1);
    chk("reset_w_z", 16'(W), 16'(ZZ));
    run_init();

    for (int i = 0; i < 16; i++) begin
      address = 4'(i);
      step();
      chk("boot_read", 16'(W), 16'(ref_mem[i]));
    end
    nCE = 1'b1;
    step();
    chk("nce_hi_z", 16'(W), 16'(ZZ));

    nCE5 = 1'b0;
    for (int i = 0; i < 32; i++) begin
      a5 = 5'(i);
      step();
      chk("boot_read5", 16'(W5), 16'(exp_init(i)));
    end
    nCE5 = 1'b1;

    // Bus write then read-back.
    address = 4'd7; W_in = 8'h5A; nWE = 1'b0; nCE = 1'b1;
    step();
    chk("wr_w_z", 16'(W), 16'(ZZ));
    ref_mem[7] = 8'h5A;
    nWE = 1'b1; nCE = 1'b0;
    step();
    chk("wr_readback", 16'(W), 16'h005A);

    // Same-edge read and write: old word first.
    address = 4'd3; W_in = 8'h33; nWE = 1'b0; nCE = 1'b0;
    exp_rd = ref_mem[3];
    step();
    chk("rw_old", 16'(W), 16'(exp_rd));
    ref_mem[3] = 8'h33;
    nWE = 1'b1;
    step();
    chk("rw_new", 16'(W), 16'h0033);

    // Manual write while bus write is attempted elsewhere.
    prog_mode = 1'b1; prog_we = 1'b1; prog_addr = 4'd2; prog_data = 8'h77;
    address = 4'd9; W_in = 8'h99; nWE = 1'b0; nCE = 1'b1;
    step();
    ref_mem[2] = 8'h77;
    prog_mode = 1'b0; prog_we = 1'b0; nWE = 1'b1; nCE = 1'b0; address = 4'd2;
    step();
    chk("prog_wr", 16'(W), 16'h0077);
    address = 4'd9;
    step();
    chk("prog_blocks_bus", 16'(W), 16'(ref_mem[9]));

    for (int k = 0; k < 400; k++) begin
      address   = 4'($urandom_range(0, 15));
      nCE       = 1'($urandom_range(0, 1));
      nWE       = ($urandom_range(0, 2) != 0);
      W_in      = 8'($urandom);
      prog_mode = ($urandom_range(0, 3) == 0);
      prog_we   = 1'($urandom_range(0, 1));
      prog_addr = 4'($urandom_range(0, 15));
      prog_data = 8'($urandom);
      if (!nCE) exp_rd = ref_mem[address];
      if (prog_mode) begin
        if (prog_we) ref_mem[prog_addr] = prog_data;
      end else if (!nWE) begin
        ref_mem[address] = W_in;
      end
      step();
      chk("rand_w", 16'(W), nCE ? 16'(ZZ) : 16'(exp_rd));
    end

    // clr mid-boot restarts; a bus write during busy must be dropped.
    prog_mode = 1'b0; prog_we = 1'b0; nWE = 1'b1; nCE = 1'b1;
    clr = 1'b1;
    step();
    clr = 1'b0;
    for (int i = 0; i < 8; i++) begin
      step();
      chk("busy_mid", 16'(busy), 16'd1);
    end
    clr = 1'b1;
    step();
    address = 4'd5; W_in = 8'hAB; nWE = 1'b0; nCE = 1'b0;
    run_init();
    step();
    chk("init_wr_dropped", 16'(W), 16'(ref_mem[5]));

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errs);
    $finish;
  end

endmodule
